// File: rtl/cmult_rr_arbiter.sv
// Round-robin arbiter/sequencer in front of one shared fixed-point complex multiplier.
// One transaction is in flight at a time. The flow is grant -> issue operands -> wait for
// the result -> return it to the granted requester. Operand and result data pass through
// untouched; only the handshakes are sequenced here.
module cmult_rr_arbiter #(
    parameter int n    = 32,
    parameter int nreq = 4,
    parameter int idw  = $clog2(nreq)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [nreq-1:0]     req_val,
    output logic [nreq-1:0]     req_rdy,
    input  logic [nreq*n-1:0]   req_ar,
    input  logic [nreq*n-1:0]   req_ac,
    input  logic [nreq*n-1:0]   req_br,
    input  logic [nreq*n-1:0]   req_bc,
    output logic [nreq-1:0]     resp_val,
    input  logic [nreq-1:0]     resp_rdy,
    output logic [n-1:0]        resp_cr,
    output logic [n-1:0]        resp_cc,
    output logic                m_recv_val,
    input  logic                m_recv_rdy,
    output logic [n-1:0]        m_ar,
    output logic [n-1:0]        m_ac,
    output logic [n-1:0]        m_br,
    output logic [n-1:0]        m_bc,
    input  logic                m_send_val,
    output logic                m_send_rdy,
    input  logic [n-1:0]        m_cr,
    input  logic [n-1:0]        m_cc,
    output logic [idw-1:0]      grant_id,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [idw-1:0] ptr_q, ptr_d;
    logic [idw-1:0] grant_q, grant_d;
    logic [n-1:0]   ar_q, ar_d, ac_q, ac_d, br_q, br_d, bc_q, bc_d;
    logic [n-1:0]   cr_q, cr_d, cc_q, cc_d;

    logic           pick_found_s;
    logic [idw-1:0] pick_idx_s;
    logic           resp_done_s;

    // Search starts just after the last completed grant, so the requester served most
    // recently is considered last. Returns {found, index}.
    function automatic logic [idw:0] rr_pick(input logic [nreq-1:0] val,
                                             input logic [idw-1:0]  ptr);
        logic           found;
        logic [idw-1:0] idx;
        logic [idw-1:0] cand;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= nreq; k++) begin
            cand = idw'((int'(ptr) + k) % nreq);
            if (!found && val[cand]) begin
                found = 1'b1;
                idx   = cand;
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    // Round-robin winner among the currently asserted requests, and the return-side handshake.
    always_comb begin
        {pick_found_s, pick_idx_s} = rr_pick(req_val, ptr_q);
        resp_done_s                = resp_rdy[grant_q];
    end

    // Next-state logic of the transaction sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick_found_s) state_d = ISSUE;
                else              state_d = IDLE;
            end
            ISSUE: begin
                if (m_recv_rdy) state_d = WAIT;
                else            state_d = ISSUE;
            end
            WAIT: begin
                if (m_send_val) state_d = RESP;
                else            state_d = WAIT;
            end
            RESP: begin
                if (resp_done_s) state_d = IDLE;
                else             state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand/result capture, grant index and pointer update.
    always_comb begin
        ptr_d   = ptr_q;
        grant_d = grant_q;
        ar_d    = ar_q;
        ac_d    = ac_q;
        br_d    = br_q;
        bc_d    = bc_q;
        cr_d    = cr_q;
        cc_d    = cc_q;
        case (state_q)
            IDLE: begin
                if (pick_found_s) begin
                    grant_d = pick_idx_s;
                    ar_d    = req_ar[pick_idx_s*n +: n];
                    ac_d    = req_ac[pick_idx_s*n +: n];
                    br_d    = req_br[pick_idx_s*n +: n];
                    bc_d    = req_bc[pick_idx_s*n +: n];
                end else begin
                    grant_d = grant_q;
                end
            end
            WAIT: begin
                if (m_send_val) begin
                    cr_d = m_cr;
                    cc_d = m_cc;
                end else begin
                    cr_d = cr_q;
                end
            end
            RESP: begin
                // The pointer moves only when a response completes; that is the fairness anchor.
                if (resp_done_s) ptr_d = grant_q;
                else             ptr_d = ptr_q;
            end
            default: begin
                ptr_d = ptr_q;
            end
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        req_rdy    = '0;
        resp_val   = '0;
        m_recv_val = 1'b0;
        m_send_rdy = 1'b0;
        busy       = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (pick_found_s) req_rdy[pick_idx_s] = 1'b1;
                else              req_rdy = '0;
            end
            ISSUE:   m_recv_val = 1'b1;
            WAIT:    m_send_rdy = 1'b1;
            RESP:    resp_val[grant_q] = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= idw'(nreq - 1);
            grant_q <= '0;
            ar_q    <= '0;
            ac_q    <= '0;
            br_q    <= '0;
            bc_q    <= '0;
            cr_q    <= '0;
            cc_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            ar_q    <= ar_d;
            ac_q    <= ac_d;
            br_q    <= br_d;
            bc_q    <= bc_d;
            cr_q    <= cr_d;
            cc_q    <= cc_d;
        end
    end

    assign m_ar     = ar_q;
    assign m_ac     = ac_q;
    assign m_br     = br_q;
    assign m_bc     = bc_q;
    assign resp_cr  = cr_q;
    assign resp_cc  = cc_q;
    assign grant_id = grant_q;

endmodule

// File: tb/tb_cmult_rr_arbiter.sv
// Scoreboard bench for cmult_rr_arbiter: requesters and a Q16.16 complex multiplier model
// are driven on the falling edge. The expected responses (hand-computed) are queued when
// stimulus is issued, and a monitor pops them on every response handshake.
module tb_cmult_rr_arbiter;
    localparam int N    = 32;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset;
    logic [NREQ-1:0]     req_val = '0;
    logic [NREQ-1:0]     req_rdy;
    logic [NREQ*N-1:0]   req_ar = '0, req_ac = '0, req_br = '0, req_bc = '0;
    logic [NREQ-1:0]     resp_val;
    logic [NREQ-1:0]     resp_rdy;
    logic [N-1:0]        resp_cr, resp_cc;
    logic                m_recv_val;
    logic                m_recv_rdy = 1'b0;
    logic [N-1:0]        m_ar, m_ac, m_br, m_bc;
    logic                m_send_val = 1'b0;
    logic                m_send_rdy;
    logic [N-1:0]        m_cr = '0, m_cc = '0;
    logic [IDW-1:0]      grant_id;
    logic                busy;

    cmult_rr_arbiter #(.n(N), .nreq(NREQ)) dut (
        .clk(clk), .reset(reset),
        .req_val(req_val), .req_rdy(req_rdy),
        .req_ar(req_ar), .req_ac(req_ac), .req_br(req_br), .req_bc(req_bc),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_cr(resp_cr), .resp_cc(resp_cc),
        .m_recv_val(m_recv_val), .m_recv_rdy(m_recv_rdy),
        .m_ar(m_ar), .m_ac(m_ac), .m_br(m_br), .m_bc(m_bc),
        .m_send_val(m_send_val), .m_send_rdy(m_send_rdy), .m_cr(m_cr), .m_cc(m_cc),
        .grant_id(grant_id), .busy(busy)
    );

    typedef struct { logic [31:0] ar, ac, br, bc, cr, cc; } vec_t;
    typedef struct { int idx; logic [31:0] ar, ac, br, bc; } req_t;
    typedef struct { int idx; logic [31:0] cr, cc; } exp_t;

    vec_t tv [8];
    req_t pend [$];
    exp_t sb [$];
    int   tests = 0;
    int   fails = 0;
    int   lat = 0;
    int   stall_cfg = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #3;
    endtask

    task automatic issue(input int idx, input int k);
        req_t r;
        exp_t e;
        r.idx = idx; r.ar = tv[k].ar; r.ac = tv[k].ac; r.br = tv[k].br; r.bc = tv[k].bc;
        e.idx = idx; e.cr = tv[k].cr; e.cc = tv[k].cc;
        pend.push_back(r);
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name, input int budget);
        int c;
        c = 0;
        while ((sb.size() != 0) && (c < budget)) begin
            step();
            c++;
        end
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    // Environment: requesters hold each queued request until accepted; multiplier model
    // returns (ar*br - ac*bc, ar*bc + ac*br) >>> 16 after 'lat' extra cycles.
    logic [NREQ-1:0] hs_req = '0;
    logic            hs_recv = 1'b0, hs_send = 1'b0, pend_res = 1'b0;
    logic [31:0]     r_cr = '0, r_cc = '0;
    int              cnt = 0, issue_cnt = 0;
    bit              found;
    longint          la, lc, lb, ld;
    logic [63:0]     pr, pi;

    always @(negedge clk) begin
        if (!reset) begin
            hs_req = '0; hs_recv = 1'b0; hs_send = 1'b0; pend_res = 1'b0;
            cnt = 0; issue_cnt = 0; m_send_val = 1'b0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (hs_req[i]) begin
                    for (int j = 0; j < pend.size(); j++) begin
                        if (pend[j].idx == i) begin
                            pend.delete(j);
                            break;
                        end
                    end
                end
            end
            if (hs_send) m_send_val = 1'b0;
            if (hs_recv) begin pend_res = 1'b1; cnt = lat; issue_cnt = 0; end
            if (pend_res && !m_send_val) begin
                if (cnt == 0) begin
                    m_send_val = 1'b1; m_cr = r_cr; m_cc = r_cc; pend_res = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
        m_recv_rdy = reset && !pend_res && !m_send_val && (issue_cnt >= stall_cfg);
        req_val = '0;
        for (int i = 0; i < NREQ; i++) begin
            found = 1'b0;
            for (int j = 0; j < pend.size(); j++) begin
                if (!found && pend[j].idx == i) begin
                    found = 1'b1;
                    req_val[i] = 1'b1;
                    req_ar[i*N +: N] = pend[j].ar;
                    req_ac[i*N +: N] = pend[j].ac;
                    req_br[i*N +: N] = pend[j].br;
                    req_bc[i*N +: N] = pend[j].bc;
                end
            end
        end
        #1;
        hs_req  = req_val & req_rdy;
        hs_recv = m_recv_val & m_recv_rdy;
        hs_send = m_send_val & m_send_rdy;
        if (m_recv_val && !m_recv_rdy) issue_cnt++;
        if (hs_recv) begin
            la = longint'($signed(m_ar)); lc = longint'($signed(m_ac));
            lb = longint'($signed(m_br)); ld = longint'($signed(m_bc));
            pr = 64'((la * lb - lc * ld) >>> 16);
            pi = 64'((la * ld + lc * lb) >>> 16);
            r_cr = pr[31:0];
            r_cc = pi[31:0];
        end
    end

    // Monitor: on every response handshake, pop the oldest expectation and compare.
    exp_t       mon_e;
    logic [3:0] mon_oh;
    always @(negedge clk) begin
        #4;
        if ((reset === 1'b1) && ((resp_val & resp_rdy) != 4'b0000)) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL resp_unexpected: resp_val=%b with no expected response", resp_val);
            end else begin
                mon_e  = sb.pop_front();
                mon_oh = 4'b0001 << mon_e.idx;
                chk("resp_val_onehot", 64'(resp_val), 64'(mon_oh));
                chk("resp_cr", 64'(resp_cr), 64'(mon_e.cr));
                chk("resp_cc", 64'(resp_cc), 64'(mon_e.cc));
                chk("resp_grant_id", 64'(grant_id), 64'(mon_e.idx));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int c;
    initial begin
        // Q16.16 vectors: a*b with hand-computed real/imaginary parts.
        tv[0] = '{32'h00018000, 32'h00020000, 32'h00008000, 32'hFFFF0000, 32'h0002C000, 32'hFFFF8000};
        tv[1] = '{32'h00010000, 32'h00000000, 32'h00020000, 32'h00030000, 32'h00020000, 32'h00030000};
        tv[2] = '{32'h00000000, 32'h00010000, 32'h00000000, 32'h00010000, 32'hFFFF0000, 32'h00000000};
        tv[3] = '{32'h00020000, 32'hFFFF0000, 32'h00010000, 32'h00010000, 32'h00030000, 32'h00010000};
        tv[4] = '{32'h00008000, 32'h00008000, 32'h00008000, 32'hFFFF8000, 32'h00008000, 32'h00000000};
        tv[5] = '{32'h00030000, 32'h00000000, 32'h00000000, 32'hFFFE0000, 32'h00000000, 32'hFFFA0000};
        tv[6] = '{32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 32'h00010000, 32'h00020000, 32'h00000000};
        tv[7] = '{32'h00018000, 32'h00000000, 32'h00018000, 32'h00000000, 32'h00024000, 32'h00000000};
        reset    = 1'b0;
        resp_rdy = 4'b1111;
        repeat (3) step();

        // Reset state
        chk("rst_req_rdy", 64'(req_rdy), 64'd0);
        chk("rst_resp_val", 64'(resp_val), 64'd0);
        chk("rst_m_recv_val", 64'(m_recv_val), 64'd0);
        chk("rst_m_send_rdy", 64'(m_send_rdy), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_m_ar", 64'(m_ar), 64'd0);
        reset = 1'b1;

        // Single request on requester 2
        issue(2, 0);
        step();
        chk("t1_req_rdy_grant", 64'(req_rdy), 64'h4);
        chk("t1_busy_idle", 64'(busy), 64'd0);
        step();
        chk("t1_req_rdy_after", 64'(req_rdy), 64'd0);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_m_recv_val", 64'(m_recv_val), 64'd1);
        chk("t1_grant_id", 64'(grant_id), 64'd2);
        chk("t1_m_ar", 64'(m_ar), 64'h00018000);
        chk("t1_m_bc", 64'(m_bc), 64'hFFFF0000);
        wait_done("t1_done", 40);

        // After reset, 0 and 3 together: 0 first, then 3
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        issue(0, 1);
        issue(3, 2);
        wait_done("t2_done", 60);

        // All four continuously for eight transactions: 0,1,2,3,0,1,2,3
        for (int k = 0; k < 8; k++) issue(k % 4, k);
        wait_done("t3_done", 200);

        // Requester 1 holds resp_rdy low for five cycles in RESP
        resp_rdy = 4'b1101;
        issue(1, 3);
        c = 0;
        while (!resp_val[1] && c < 40) begin step(); c++; end
        chk("t4_resp_seen", 64'(resp_val[1]), 64'd1);
        issue(2, 4);
        for (int k = 0; k < 5; k++) begin
            if (k != 0) step();
            chk("t4_hold_resp_val", 64'(resp_val), 64'h2);
            chk("t4_hold_cr", 64'(resp_cr), 64'h00030000);
            chk("t4_hold_cc", 64'(resp_cc), 64'h00010000);
            chk("t4_hold_req_rdy", 64'(req_rdy), 64'd0);
            chk("t4_hold_m_recv_val", 64'(m_recv_val), 64'd0);
        end
        resp_rdy = 4'b1111;
        step();
        chk("t4_released_resp_val", 64'(resp_val), 64'd0);
        chk("t4_next_grant", 64'(req_rdy), 64'h4);
        wait_done("t4_done", 60);

        // Multiplier stalls m_recv_rdy for three cycles in ISSUE
        stall_cfg = 3;
        issue(0, 5);
        c = 0;
        while (!m_recv_val && c < 40) begin step(); c++; end
        for (int k = 0; k < 4; k++) begin
            if (k != 0) step();
            chk("t5_issue_hold_val", 64'(m_recv_val), 64'd1);
            chk("t5_issue_hold_ar", 64'(m_ar), 64'h00030000);
            chk("t5_issue_hold_bc", 64'(m_bc), 64'hFFFE0000);
        end
        step();
        chk("t5_left_issue", 64'(m_recv_val), 64'd0);
        chk("t5_in_wait", 64'(m_send_rdy), 64'd1);
        stall_cfg = 0;
        wait_done("t5_done", 40);

        // Reset during WAIT abandons the transaction; a fresh request then completes
        lat = 10;
        issue(1, 6);
        c = 0;
        while (!m_send_rdy && c < 40) begin step(); c++; end
        chk("t6_reached_wait", 64'(m_send_rdy), 64'd1);
        reset = 1'b0;
        step();
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_resp_val", 64'(resp_val), 64'd0);
        chk("t6_rst_m_send_rdy", 64'(m_send_rdy), 64'd0);
        chk("t6_rst_grant_id", 64'(grant_id), 64'd0);
        chk("t6_rst_m_ar", 64'(m_ar), 64'd0);
        reset = 1'b1;
        lat = 0;
        sb.delete();
        issue(0, 7);
        wait_done("t6_done", 40);
        repeat (3) step();
        chk("end_pending_empty", 64'(pend.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
